matrix_multiplier_seq: RTL

Parametrised, row-serial successor to the combinational-core matrix multiplier. Captures A (ROWS_A x COLS_A) and B (COLS_A x COLS_B) through a valid/ready handshake. Computes one row of C per cycle on a shared row-MAC array, with selectable signed/unsigned arithmetic and saturate/wrap output narrowing. Presents the full C under output valid/ready backpressure. Sits between the operand buffers and the result consumer in the accelerator datapath.

---
 rtl/mm_pkg.sv | 26 ++
 rtl/mm_row_mac.sv | 23 ++
 rtl/matrix_multiplier_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared types and arithmetic helpers for the row-serial matrix multiplier
package mm_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} mm_state_t;
  localparam int MAXW = 64;
  typedef struct packed {
    logic ovf;
    logic [MAXW-1:0] val;
  } narrow_t;
  function automatic int acc_width(input int dw, input int ca);
    return 2 * dw + ((ca > 1) ? $clog2(ca) : 1);
  endfunction
  function automatic narrow_t narrow(input logic [MAXW-1:0] acc, input logic sgn, input logic sat, input int ow);
    narrow_t r;
    logic [MAXW-1:0] hi, lo, mask, wrapped;
    logic over, under;
    mask = (MAXW'(1) << ow) - MAXW'(1);
    hi = sgn ? (MAXW'(1) << (ow - 1)) - MAXW'(1) : mask;
    lo = sgn ? ~hi : '0;
    over = sgn ? ($signed(acc) > $signed(hi)) : (acc > hi);
    under = sgn && ($signed(acc) < $signed(lo));
    wrapped = (sgn && acc[ow-1]) ? (acc & mask) | ~mask : acc & mask;
    r.val = sat ? (over ? hi : under ? lo : acc) : wrapped;
    r.ovf = sat ? (over | under) : (wrapped != acc);
    return r;
  endfunction
endpackage

// File: rtl/mm_row_mac.sv
// mm_row_mac: one row of A times all of B; ports a_row (one A row), b (full B), acc (COLS_B sums)
module mm_row_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int COLS_A = 2,
  parameter int COLS_B = 2,
  parameter int ACC_WIDTH = 17,
  parameter int SIGNED = 0
) (
  input  logic [COLS_A*DATA_WIDTH-1:0] a_row,
  input  logic [COLS_A*COLS_B*DATA_WIDTH-1:0] b,
  output logic [COLS_B*ACC_WIDTH-1:0] acc
);
  function automatic logic [ACC_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] x);
    return {{(ACC_WIDTH-DATA_WIDTH){SIGNED != 0 && x[DATA_WIDTH-1]}}, x};
  endfunction
  always_comb begin
    acc = '0;
    for (int j = 0; j < COLS_B; j++)
      for (int k = 0; k < COLS_A; k++)
        acc[j*ACC_WIDTH +: ACC_WIDTH] = acc[j*ACC_WIDTH +: ACC_WIDTH]
          + ext(a_row[k*DATA_WIDTH +: DATA_WIDTH]) * ext(b[(k*COLS_B+j)*DATA_WIDTH +: DATA_WIDTH]);
  end
endmodule

// File: rtl/matrix_multiplier_seq.sv
// matrix_multiplier_seq: row-serial C = A*B with valid/ready in (a, b) and out (c, ovf); busy while not IDLE
module matrix_multiplier_seq
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS_A = 2,
  parameter int COLS_A = 2,
  parameter int COLS_B = 2,
  parameter int OUT_WIDTH = 16,
  parameter int SIGNED = 0,
  parameter int SATURATE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [ROWS_A*COLS_A*DATA_WIDTH-1:0] a,
  input  logic [COLS_A*COLS_B*DATA_WIDTH-1:0] b,
  output logic out_valid,
  input  logic out_ready,
  output logic [ROWS_A*COLS_B*OUT_WIDTH-1:0] c,
  output logic ovf,
  output logic busy
);
  localparam int ACCW = acc_width(DATA_WIDTH, COLS_A);
  localparam int RW = ROWS_A > 1 ? $clog2(ROWS_A) : 1;
  localparam int AR = COLS_A * DATA_WIDTH;
  localparam int CR = COLS_B * OUT_WIDTH;
  mm_state_t state;
  logic [ROWS_A*AR-1:0] a_q;
  logic [COLS_A*COLS_B*DATA_WIDTH-1:0] b_q;
  logic [RW-1:0] row;
  logic [COLS_B*ACCW-1:0] acc;
  logic [CR-1:0] row_c;
  logic row_ovf;
  logic [MAXW-1:0] wide;
  narrow_t n;
  mm_row_mac #(.DATA_WIDTH(DATA_WIDTH), .COLS_A(COLS_A), .COLS_B(COLS_B), .ACC_WIDTH(ACCW), .SIGNED(SIGNED))
    u_mac (.a_row(a_q[int'(row)*AR +: AR]), .b(b_q), .acc(acc));
  always_comb begin
    row_c = '0;
    row_ovf = 1'b0;
    wide = '0;
    n = '0;
    for (int j = 0; j < COLS_B; j++) begin
      wide = {{(MAXW-ACCW){SIGNED != 0 && acc[j*ACCW+ACCW-1]}}, acc[j*ACCW +: ACCW]};
      n = narrow(wide, SIGNED != 0, SATURATE != 0, OUT_WIDTH);
      row_c[j*OUT_WIDTH +: OUT_WIDTH] = n.val[OUT_WIDTH-1:0];
      row_ovf = row_ovf | n.ovf;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      c <= '0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          row <= '0;
          ovf <= 1'b0;
          in_ready <= 1'b0;
          busy <= 1'b1;
          state <= COMPUTE;
        end
        COMPUTE: begin
          c[int'(row)*CR +: CR] <= row_c;
          ovf <= ovf | row_ovf;
          row <= row + 1'b1;
          if (row == RW'(ROWS_A - 1)) begin
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
